binary_to_gray: RTL
===================

BINARY_TO_GRAY -- requirements
Module: binary_to_gray

Interface
REQ-001 Parameter BIN_THRESH, default 10'd512: iDATA at or above this value decodes as binary 1, below as 0.
REQ-002 Parameter WIN_LOG2, default 3: sliding window length N = 2^WIN_LOG2 pixels; legal range 1..4.
REQ-003 iCLK  input  1  clock; all state updates on the rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-low.
REQ-005 iDVAL  input  1  input pixel valid; one pixel per cycle while high; low marks a line gap.
REQ-006 iDATA  input  10  binary-image pixel, nominally 0 or 1023; any value is decoded per REQ-001.
REQ-007 oDVAL  output  1  output pixel valid, aligned with oDATA and oX.
REQ-008 oDATA  output  10  reconstructed gray level for the pixel.
REQ-009 oX  output  12  column index of the output pixel within its line.

Function
REQ-010 Stage 1 SHALL decode bit b = (iDATA >= BIN_THRESH) on every cycle with iDVAL high.
REQ-011 The block SHALL keep an N-bit shift register W of the last N decoded bits of the current line, plus a count C (WIN_LOG2+1 bits) of ones in W.
REQ-012 On each valid pixel: W shifts in b, oldest bit w_old is dropped, C <= C + b - w_old; C SHALL always equal popcount(W), never exceeding N.
REQ-013 Line start: the first valid cycle after any cycle with iDVAL low SHALL see W and C as zero before the shift, giving a zero-padded left edge.
REQ-014 On any cycle with iDVAL low, W and C SHALL clear to zero and the column counter SHALL reset to 0.
REQ-015 Column counter: 0 on the first pixel of a line, +1 per valid pixel, saturating at 4095 (no wrap).
REQ-016 Stage 2 SHALL scale C to gray: C == N -> 1023; otherwise C << (10 - WIN_LOG2), truncated to 10 bits.
REQ-017 Latency SHALL be exactly 2 cycles: oDVAL(t) = iDVAL(t-2); oDATA and oX correspond to the pixel presented at t-2.
REQ-018 When oDVAL is low, oDATA and oX SHALL be 0.
REQ-019 Back-to-back lines separated by a single low cycle of iDVAL SHALL be handled with no pixel loss and full window clear.
REQ-020 No backpressure is supported: every valid input produces exactly one valid output.

Reset
REQ-021 While iRST is low: oDVAL = 0, oDATA = 0, oX = 0, W = 0, C = 0, column counter = 0, all pipeline registers = 0.
REQ-022 Reset asserted mid-line SHALL abort the line; the first valid pixel after release SHALL be treated as a line start.
REQ-023 The first valid output after release SHALL appear exactly 2 cycles after the first iDVAL-high cycle.

Verification
REQ-024 N=8; one line of 12 pixels all 1023 -> oDATA = 128,256,384,512,640,768,896,1023,1023,1023,1023,1023; oX = 0..11; oDVAL high for 12 cycles starting 2 cycles after the first input.
REQ-025 N=8; alternating 1023,0,... for 16 pixels -> after the window fills, oDATA alternates 512 (C=4) every cycle; C never exceeds 8.
REQ-026 Threshold boundary: iDATA = 511 decodes as 0 and 512 decodes as 1; single-pixel lines -> oDATA = 0 and 128 respectively.
REQ-027 Two lines of 1023 separated by one iDVAL-low cycle -> second line restarts at oDATA = 128, oX = 0; one low output cycle between the lines.
REQ-028 iRST pulsed low for 1 cycle mid-line with iDVAL held high -> outputs 0 during reset; after release, the line restarts at oX = 0, oDATA = 128 for a 1023 pixel.
REQ-029 Line of 5000 valid pixels -> oX reaches 4095 and holds there for the remaining pixels.

Source files
------------

// File: rtl/binary_to_gray_if.sv
// Pixel stream bundle between the binary source and the gray reconstruction.
// The master drives pixels in and the slave returns the reconstructed gray stream.
interface binary_to_gray_if;
  logic        iDVAL;
  logic [9:0]  iDATA;
  logic        oDVAL;
  logic [9:0]  oDATA;
  logic [11:0] oX;

  modport master (
    output iDVAL,
    output iDATA,
    input  oDVAL,
    input  oDATA,
    input  oX
  );

  modport slave (
    input  iDVAL,
    input  iDATA,
    output oDVAL,
    output oDATA,
    output oX
  );
endinterface

// File: rtl/binary_to_gray.sv
// Binary-to-gray reconstruction: a sliding-window popcount over each line,
// scaled to a 10-bit gray level. The pipeline is two stages with no backpressure.
module binary_to_gray #(
  parameter logic [9:0] BIN_THRESH = 10'd512,
  parameter int         WIN_LOG2   = 3
) (
  input  logic            iCLK,
  input  logic            iRST,
  binary_to_gray_if.slave bus
);
  localparam int N  = 1 << WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam int SH = 10 - WIN_LOG2;
  localparam logic [CW-1:0] C_FULL  = CW'(N);
  localparam logic [11:0]   COL_MAX = 12'hFFF;

  logic [N-1:0]  win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   col_q, col_d;

  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] s1_cnt_q, s1_cnt_d;
  logic [11:0]   s1_x_q, s1_x_d;

  logic          vld_q, vld_d;
  logic [9:0]    data_q, data_d;
  logic [11:0]   x_q, x_d;

  logic          bit_in;
  logic [9:0]    gray;

  // A low iDVAL cycle clears the window so each line starts zero-padded.
  always_comb begin
    bit_in   = (bus.iDATA >= BIN_THRESH);
    win_d    = '0;
    cnt_d    = '0;
    col_d    = '0;
    s1_vld_d = bus.iDVAL;
    s1_cnt_d = '0;
    s1_x_d   = '0;
    if (bus.iDVAL) begin
      win_d    = {win_q[N-2:0], bit_in};
      cnt_d    = cnt_q + CW'(bit_in)
               - CW'(win_q[N-1]);
      col_d    = (col_q == COL_MAX)
               ? COL_MAX : col_q + 12'd1;
      s1_cnt_d = cnt_d;
      s1_x_d   = col_q;
    end
  end

  always_comb begin
    gray   = 10'(s1_cnt_q) << SH;
    vld_d  = s1_vld_q;
    data_d = '0;
    x_d    = '0;
    if (s1_vld_q) begin
      data_d = (s1_cnt_q == C_FULL)
             ? 10'd1023 : gray;
      x_d    = s1_x_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      win_q    <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_cnt_q <= '0;
      s1_x_q   <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      x_q      <= '0;
    end else begin
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      s1_vld_q <= s1_vld_d;
      s1_cnt_q <= s1_cnt_d;
      s1_x_q   <= s1_x_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      x_q      <= x_d;
    end
  end

  assign bus.oDVAL = vld_q;
  assign bus.oDATA = data_q;
  assign bus.oX    = x_q;
endmodule
